// File: rtl/usb_autodetect_if.sv
// Bundle of the register-block-facing inputs and PHY-facing outputs of the
// USB speed auto-detector; master drives the inputs, slave is the detector.
interface usb_autodetect_if #(
  parameter int pCOUNTER_WIDTH = 24
);
  logic                      I_restart;
  logic [pCOUNTER_WIDTH-1:0] I_wait1;
  logic [pCOUNTER_WIDTH-1:0] I_wait2;
  logic [1:0]                I_xcvrsel_auto;
  logic                      I_termsel_auto;
  logic [1:0]                I_linestate;
  logic [1:0]                O_xcvrsel;
  logic                      O_termsel;
  logic [1:0]                O_speed;
  logic                      O_busy;
  logic                      O_done;

  modport master (
    output I_restart, I_wait1, I_wait2, I_xcvrsel_auto, I_termsel_auto, I_linestate,
    input  O_xcvrsel, O_termsel, O_speed, O_busy, O_done
  );

  modport slave (
    input  I_restart, I_wait1, I_wait2, I_xcvrsel_auto, I_termsel_auto, I_linestate,
    output O_xcvrsel, O_termsel, O_speed, O_busy, O_done
  );
endinterface

// File: rtl/usb_autodetect.sv
// USB bus speed detector: settles the PHY with auto selects, watches LINESTATE for
// an observation window, then reports LS/FS/HS and drives matching PHY selects.
module usb_autodetect #(
  parameter int pCOUNTER_WIDTH = 24,
  parameter int pCHIRP_PAIRS   = 3,
  parameter int pIDLE_MIN      = 16
) (
  input  logic         fe_clk,
  input  logic         reset_n,
  usb_autodetect_if.slave bus
);
  localparam int RW = $clog2(pIDLE_MIN + 1);
  localparam int KW = $clog2(pCHIRP_PAIRS + 1);
  localparam logic [RW-1:0] IDLE_MIN_C = RW'(pIDLE_MIN);
  localparam logic [KW-1:0] PAIRS_C    = KW'(pCHIRP_PAIRS);
  localparam logic [1:0] LS_J = 2'b01;
  localparam logic [1:0] LS_K = 2'b10;
  localparam logic [1:0] SPD_NONE = 2'b00;
  localparam logic [1:0] SPD_FS   = 2'b01;
  localparam logic [1:0] SPD_HS   = 2'b10;
  localparam logic [1:0] SPD_LS   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_OBSERVE, ST_DONE} state_t;

  state_t                    state_q, state_d;
  logic [pCOUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [pCOUNTER_WIDTH-1:0] wait1_q, wait1_d;
  logic [pCOUNTER_WIDTH-1:0] wait2_q, wait2_d;
  logic [1:0]                xa_q, xa_d;
  logic                      ta_q, ta_d;
  logic [1:0]                ls_q, ls_d;
  logic [1:0]                ls_prev_q, ls_prev_d;
  logic [RW-1:0]             run_q, run_d, run_nx;
  logic [KW-1:0]             kj_q, kj_d, kj_nx;
  logic                      fs_seen_q, fs_seen_d;
  logic                      ls_seen_q, ls_seen_d;
  logic [1:0]                speed_q, speed_d;
  logic [1:0]                xcvrsel_q, xcvrsel_d;
  logic                      termsel_q, termsel_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait1_q   <= '0;
      wait2_q   <= '0;
      xa_q      <= 2'b01;
      ta_q      <= 1'b1;
      ls_q      <= 2'b00;
      ls_prev_q <= 2'b00;
      run_q     <= '0;
      kj_q      <= '0;
      fs_seen_q <= 1'b0;
      ls_seen_q <= 1'b0;
      speed_q   <= SPD_NONE;
      xcvrsel_q <= 2'b01;
      termsel_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait1_q   <= wait1_d;
      wait2_q   <= wait2_d;
      xa_q      <= xa_d;
      ta_q      <= ta_d;
      ls_q      <= ls_d;
      ls_prev_q <= ls_prev_d;
      run_q     <= run_d;
      kj_q      <= kj_d;
      fs_seen_q <= fs_seen_d;
      ls_seen_q <= ls_seen_d;
      speed_q   <= speed_d;
      xcvrsel_q <= xcvrsel_d;
      termsel_q <= termsel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait1_d   = wait1_q;
    wait2_d   = wait2_q;
    xa_d      = xa_q;
    ta_d      = ta_q;
    ls_d      = bus.I_linestate;
    ls_prev_d = ls_q;
    run_d     = run_q;
    kj_d      = kj_q;
    fs_seen_d = fs_seen_q;
    ls_seen_d = ls_seen_q;
    speed_d   = speed_q;
    xcvrsel_d = xcvrsel_q;
    termsel_d = termsel_q;

    // Run length of the current linestate, and K->J chirp edge count, both saturating.
    run_nx = (ls_q == ls_prev_q) ? ((run_q == IDLE_MIN_C) ? run_q : run_q + 1'b1)
                                 : {{(RW-1){1'b0}}, 1'b1};
    kj_nx  = (ls_prev_q == LS_K && ls_q == LS_J && kj_q != PAIRS_C) ? kj_q + 1'b1 : kj_q;

    case (state_q)
      ST_SETTLE: begin
        if (wait1_q == '0 || cnt_q == wait1_q - 1'b1) begin
          state_d = ST_OBSERVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OBSERVE: begin
        cnt_d     = cnt_q + 1'b1;
        run_d     = run_nx;
        kj_d      = kj_nx;
        fs_seen_d = fs_seen_q | (run_nx == IDLE_MIN_C && ls_q == LS_J);
        ls_seen_d = ls_seen_q | (run_nx == IDLE_MIN_C && ls_q == LS_K && kj_q == '0);
        if (kj_nx == PAIRS_C) begin
          state_d = ST_DONE;
          speed_d = SPD_HS;
        end else if (wait2_q == '0 || cnt_q == wait2_q - 1'b1) begin
          state_d = ST_DONE;
          speed_d = ls_seen_d ? SPD_LS : (fs_seen_d ? SPD_FS : SPD_NONE);
        end
      end
      default: ;
    endcase

    // A restart overrides whatever the current state decided, including a window end.
    if (bus.I_restart) begin
      state_d   = ST_SETTLE;
      cnt_d     = '0;
      run_d     = '0;
      kj_d      = '0;
      fs_seen_d = 1'b0;
      ls_seen_d = 1'b0;
      speed_d   = SPD_NONE;
      wait1_d   = bus.I_wait1;
      wait2_d   = bus.I_wait2;
      xa_d      = bus.I_xcvrsel_auto;
      ta_d      = bus.I_termsel_auto;
    end

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_OBSERVE);
    done_d = (state_d == ST_DONE);
    if (busy_d) begin
      xcvrsel_d = xa_d;
      termsel_d = ta_d;
    end else if (done_d) begin
      case (speed_d)
        SPD_HS:  begin xcvrsel_d = 2'b00; termsel_d = 1'b0; end
        SPD_FS:  begin xcvrsel_d = 2'b01; termsel_d = 1'b1; end
        SPD_LS:  begin xcvrsel_d = 2'b10; termsel_d = 1'b1; end
        default: begin xcvrsel_d = xa_d;  termsel_d = ta_d; end
      endcase
    end
  end

  assign bus.O_xcvrsel = xcvrsel_q;
  assign bus.O_termsel = termsel_q;
  assign bus.O_speed   = speed_q;
  assign bus.O_busy    = busy_q;
  assign bus.O_done    = done_q;
endmodule

// File: tb/tb_usb_autodetect.sv
// Bench for usb_autodetect: directed runs with hand-derived results plus randomized
// linestate/restart traffic compared every cycle against a window-level model.
module tb_usb_autodetect;
  localparam int W     = 24;
  localparam int PAIRS = 3;
  localparam int IDLE  = 16;
  localparam int MAXC  = 8192;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] LJ  = 2'b01;
  localparam logic [1:0] LK  = 2'b10;

  logic fe_clk  = 1'b0;
  logic reset_n = 1'b0;

  usb_autodetect_if #(.pCOUNTER_WIDTH(W)) bus ();

  usb_autodetect #(
    .pCOUNTER_WIDTH(W),
    .pCHIRP_PAIRS  (PAIRS),
    .pIDLE_MIN     (IDLE)
  ) dut (
    .fe_clk (fe_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 fe_clk = ~fe_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit chk_en       = 1'b0;

  // Model: linestate seen at each clock edge, plus the parameters of the current run.
  logic [1:0] hist [MAXC];
  bit         active, finished;
  int         start, m1, m2;
  logic [1:0] xa;
  logic       ta;
  logic       exp_busy  = 1'b0;
  logic       exp_done  = 1'b0;
  logic [1:0] exp_speed = 2'b00;
  logic [1:0] exp_xcvr  = 2'b01;
  logic       exp_term  = 1'b1;

  task automatic chk(string nm, int act, int expv);
    tests_run++;
    if (act != expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Length of the identical-linestate streak ending at edge e, counted inside the window.
  function automatic int streak(int e);
    int n = 1;
    while (n < IDLE && (e - n) >= start + m1 && hist[e - n] == hist[e]) n++;
    return n;
  endfunction

  function automatic int kj_upto(int e);
    int n = 0;
    for (int i = start + m1; i <= e; i++)
      if (hist[i - 1] == LK && hist[i] == LJ) n++;
    return (n > PAIRS) ? PAIRS : n;
  endfunction

  function automatic void set_idle();
    active = 1'b0; finished = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_speed = 2'b00; exp_xcvr = 2'b01; exp_term = 1'b1;
  endfunction

  function automatic void end_run(logic [1:0] sp);
    finished = 1'b1; exp_busy = 1'b0; exp_done = 1'b1; exp_speed = sp;
    case (sp)
      2'b10:   begin exp_xcvr = 2'b00; exp_term = 1'b0; end
      2'b01:   begin exp_xcvr = 2'b01; exp_term = 1'b1; end
      2'b11:   begin exp_xcvr = 2'b10; exp_term = 1'b1; end
      default: begin exp_xcvr = xa;    exp_term = ta;   end
    endcase
  endfunction

  task automatic model_edge();
    int  j, e, s;
    bit  fs, lsn;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    hist[cyc] = reset_n ? bus.I_linestate : 2'b00;
    if (!reset_n) begin
      set_idle();
    end else if (bus.I_restart) begin
      active = 1'b1; finished = 1'b0; start = cyc;
      m1 = (bus.I_wait1 == 0) ? 1 : int'(bus.I_wait1);
      m2 = (bus.I_wait2 == 0) ? 1 : int'(bus.I_wait2);
      xa = bus.I_xcvrsel_auto; ta = bus.I_termsel_auto;
      exp_busy = 1'b1; exp_done = 1'b0; exp_speed = 2'b00; exp_xcvr = xa; exp_term = ta;
    end else if (active && !finished) begin
      j = cyc - start;
      if (j > m1 && j <= m1 + m2) begin
        if (kj_upto(cyc - 1) >= PAIRS) begin
          end_run(2'b10);
        end else if (j == m1 + m2) begin
          fs = 1'b0; lsn = 1'b0;
          for (int jj = m1 + 1; jj <= j; jj++) begin
            e = start + jj - 1;
            s = streak(e);
            if (s == IDLE && hist[e] == LJ) fs = 1'b1;
            if (s == IDLE && hist[e] == LK && kj_upto(e) == 0) lsn = 1'b1;
          end
          end_run(lsn ? 2'b11 : (fs ? 2'b01 : 2'b00));
        end
      end
    end
    cyc++;
  endtask

  always @(negedge fe_clk) begin
    if (chk_en) begin
      tests_run++;
      if ({bus.O_busy, bus.O_done, bus.O_speed, bus.O_xcvrsel, bus.O_termsel} !==
          {exp_busy, exp_done, exp_speed, exp_xcvr, exp_term}) begin
        tests_failed++;
        $display("FAIL cycle %0d outputs(busy done speed xcvrsel termsel): got %b %b %b %b %b expected %b %b %b %b %b",
                 cyc, bus.O_busy, bus.O_done, bus.O_speed, bus.O_xcvrsel, bus.O_termsel,
                 exp_busy, exp_done, exp_speed, exp_xcvr, exp_term);
      end
    end
  end

  task automatic step(bit rs, logic [1:0] ls);
    bus.I_restart   = rs;
    bus.I_linestate = ls;
    @(posedge fe_clk);
    model_edge();
    #1;
    bus.I_restart = 1'b0;
  endtask

  function automatic logic [1:0] pat_ls(int pat, int j);
    case (pat)
      0: return LJ;
      1: return LK;
      2: return SE0;
      default: begin
        if (j <= 10) return LJ;
        if (j < 31) return LK;
        return (((j - 31) / 8) % 2 == 0) ? LJ : LK;
      end
    endcase
  endfunction

  // Pulses restart, then reports the edge offset at which O_done was first seen (-1 if never).
  task automatic run_pattern(int w1, int w2, int pat, int budget, output int off);
    bus.I_wait1 = W'(w1);
    bus.I_wait2 = W'(w2);
    off = -1;
    step(1'b1, pat_ls(pat, 0));
    bus.I_wait1 = W'($urandom_range(0, 5));
    bus.I_wait2 = W'($urandom_range(0, 5));
    if (bus.O_done) off = 0;
    for (int j = 1; j <= budget && off < 0; j++) begin
      step(1'b0, pat_ls(pat, j));
      if (bus.O_done) off = j;
    end
  endtask

  initial begin
    int off, seen;
    bit rs;
    int mode, per, ph;
    logic [1:0] cur;

    bus.I_restart = 1'b0; bus.I_wait1 = '0; bus.I_wait2 = '0;
    bus.I_xcvrsel_auto = 2'b11; bus.I_termsel_auto = 1'b0; bus.I_linestate = LJ;
    set_idle();
    step(1'b0, LJ);
    chk_en = 1'b1;
    step(1'b0, LJ);
    step(1'b0, LJ);
    reset_n = 1'b1;
    chk("reset_xcvrsel", bus.O_xcvrsel, 1);
    chk("reset_termsel", bus.O_termsel, 1);
    chk("reset_speed",   bus.O_speed,   0);

    run_pattern(10, 100, 0, 200, off);
    chk("fs_done_offset", off, 110);
    chk("fs_speed", bus.O_speed, 1);
    chk("fs_termsel", bus.O_termsel, 1);

    run_pattern(10, 1000, 3, 1100, off);
    chk("hs_done_offset", off, 64);
    chk("hs_speed", bus.O_speed, 2);
    chk("hs_xcvrsel", bus.O_xcvrsel, 0);
    chk("hs_termsel", bus.O_termsel, 0);

    run_pattern(10, 50, 1, 200, off);
    chk("ls_done_offset", off, 60);
    chk("ls_speed", bus.O_speed, 3);
    chk("ls_xcvrsel", bus.O_xcvrsel, 2);

    run_pattern(10, 50, 2, 200, off);
    chk("se0_speed", bus.O_speed, 0);
    chk("se0_xcvrsel_auto", bus.O_xcvrsel, 3);

    run_pattern(0, 0, 0, 10, off);
    chk("zero_wait_done_offset", off, 2);
    chk("zero_wait_speed", bus.O_speed, 0);

    // Restart 40 cycles into the observation window.
    bus.I_wait1 = W'(10); bus.I_wait2 = W'(100);
    step(1'b1, LJ);
    seen = 0;
    for (int j = 1; j <= 50; j++) begin
      step(1'b0, LJ);
      if (bus.O_done) seen++;
    end
    chk("mid_restart_no_done", seen, 0);
    run_pattern(10, 100, 0, 200, off);
    chk("mid_restart_done_offset", off, 110);

    // Restart landing exactly on the window-end edge.
    bus.I_wait1 = W'(10); bus.I_wait2 = W'(100);
    step(1'b1, LJ);
    for (int j = 1; j <= 109; j++) step(1'b0, LJ);
    run_pattern(10, 100, 0, 200, off);
    chk("window_end_restart_offset", off, 110);

    // Asynchronous reset in the middle of an observation window.
    bus.I_wait1 = W'(10); bus.I_wait2 = W'(100);
    step(1'b1, LJ);
    for (int j = 1; j <= 50; j++) step(1'b0, LJ);
    reset_n = 1'b0;
    set_idle();
    #1;
    chk("async_reset_busy", bus.O_busy, 0);
    chk("async_reset_done", bus.O_done, 0);
    chk("async_reset_speed", bus.O_speed, 0);
    chk("async_reset_xcvrsel", bus.O_xcvrsel, 1);
    step(1'b0, LJ);
    step(1'b0, LJ);
    reset_n = 1'b1;

    mode = 0; per = 8; ph = 0; cur = LJ;
    for (int i = 0; i < 4000; i++) begin
      rs = (i == 0) || ($urandom_range(0, 149) == 0);
      bus.I_wait1 = W'($urandom_range(0, 20));
      bus.I_wait2 = W'($urandom_range(0, 120));
      bus.I_xcvrsel_auto = 2'($urandom_range(0, 3));
      bus.I_termsel_auto = 1'($urandom_range(0, 1));
      if (rs) begin
        mode = $urandom_range(0, 2);
        per  = $urandom_range(3, 10);
        ph   = 0;
      end
      case (mode)
        0: cur = 2'($urandom_range(0, 3));
        1: if ($urandom_range(0, 39) == 0) cur = 2'($urandom_range(0, 3));
        default: begin
          ph++;
          if (ph >= per) begin
            ph  = 0;
            cur = (cur == LK) ? LJ : LK;
          end
        end
      endcase
      step(rs, cur);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
